// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : fetch FSM state encoding
//   FETCH_ADDR_W  : default PC / instruction-memory address width
//   FETCH_INSTR_W : default instruction word width
//   FETCH_CNT_W   : width of the optional fetch performance counter
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 8;
  localparam int unsigned FETCH_INSTR_W = 16;
  localparam int unsigned FETCH_CNT_W   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDrain,
    StHold
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage sitting directly after the ProgramCounter.
// Issues one outstanding read per instruction to instruction memory, latches the returned word
// and offers it to the decoder over valid/ready. enable_increment pulses once per fetched word
// so the PC only advances after a fetch has completed.
//
// Optional build macro: FETCH_PERF_CNT_EN adds a saturating fetch_count output that counts
// accepted (valid && ready && !flush) transfers.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   pc                current PC from the ProgramCounter
//   enable_increment  one-cycle pulse back to the ProgramCounter
//   mem_req/mem_addr  read request strobe and address (address is a pc pass-through)
//   mem_rdata/rvalid  read response, latency of one or more cycles
//   flush             kill held and in-flight instruction
//   instr_valid/instr/instr_pc/instr_ready   decoder handshake
//   fetch_count       (FETCH_PERF_CNT_EN only) accepted-transfer counter
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = FETCH_ADDR_W,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               enable_increment,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_rvalid,
  input  logic               flush,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [FETCH_CNT_W-1:0] fetch_count
`endif
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] addr_q;

  // The request is a pure function of state; the address simply follows pc.
  assign mem_req  = (state_q == StReq);
  assign mem_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      addr_q           <= '0;
      instr            <= '0;
      instr_pc         <= '0;
      instr_valid      <= 1'b0;
      enable_increment <= 1'b0;
    end else begin
      enable_increment <= 1'b0;
      case (state_q)
        StIdle: begin
          instr_valid <= 1'b0;
          state_q     <= StReq;
        end
        StReq: begin
          addr_q <= pc;
          // The request has already gone out; a flush must still absorb its response.
          state_q <= flush ? StDrain : StWait;
        end
        StWait: begin
          if (flush) begin
            // Response arriving with the flush is dropped on the floor.
            state_q <= mem_rvalid ? StReq : StDrain;
          end else if (mem_rvalid) begin
            instr            <= mem_rdata;
            instr_pc         <= addr_q;
            instr_valid      <= 1'b1;
            enable_increment <= 1'b1;
            state_q          <= StHold;
          end
        end
        StHold: begin
          if (flush || instr_ready) begin
            instr_valid <= 1'b0;
            state_q     <= StReq;
          end
        end
        StDrain: begin
          // A flush here changes nothing: the orphaned response still retires the drain,
          // otherwise the stage would wait forever for a second response.
          if (mem_rvalid) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (instr_valid && instr_ready && !flush && (fetch_count != '1)) begin
      fetch_count <= fetch_count + {{(FETCH_CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule
